// File: rtl/addsub_arbiter.sv
// addsub_arbiter: two-requester round-robin arbiter around one registered 32-bit add/sub; define ADDSUB_ARB_SAT_EN to saturate res on signed overflow
module addsub_arbiter #(
  parameter bit PRIO_INIT = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        req1,
  input  logic [31:0] a0,
  input  logic [31:0] b0,
  input  logic [31:0] a1,
  input  logic [31:0] b1,
  input  logic        sub0,
  input  logic        sub1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        rsp_valid0,
  output logic        rsp_valid1,
  input  logic        rsp_ready0,
  input  logic        rsp_ready1,
  output logic [31:0] res,
  output logic        res_cout,
  output logic        res_v,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
  state_t state_q, state_d;
  logic ptr_q, ptr_d, own_q, own_d, sub_q, sub_d, cout_q, cout_d, v_q, v_d;
  logic [31:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic [31:0] bx, sum, res_n;
  logic c31, c32;
  assign bx = b_q ^ {32{sub_q}};
  assign {c32, sum} = {1'b0, a_q} + {1'b0, bx} + {32'd0, sub_q};
  // carry into the sign bit recovered from the sign-bit sum
  assign c31 = a_q[31] ^ bx[31] ^ sum[31];
`ifdef ADDSUB_ARB_SAT_EN
  assign res_n = (c31 ^ c32) ? (a_q[31] ? 32'h8000_0000 : 32'h7FFF_FFFF) : sum;
`else
  assign res_n = sum;
`endif
  assign gnt0 = !rst && state_q == IDLE && req0 && (!req1 || !ptr_q);
  assign gnt1 = !rst && state_q == IDLE && req1 && (!req0 || ptr_q);
  assign rsp_valid0 = state_q == DONE && !own_q;
  assign rsp_valid1 = state_q == DONE && own_q;
  assign busy = state_q != IDLE;
  assign res = res_q;
  assign res_cout = cout_q;
  assign res_v = v_q;
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    own_d = own_q;
    a_d = a_q;
    b_d = b_q;
    sub_d = sub_q;
    res_d = res_q;
    cout_d = cout_q;
    v_d = v_q;
    case (state_q)
      IDLE: if (gnt0 || gnt1) begin
        state_d = EXEC;
        own_d = gnt1;
        a_d = gnt1 ? a1 : a0;
        b_d = gnt1 ? b1 : b0;
        sub_d = gnt1 ? sub1 : sub0;
      end
      EXEC: begin
        state_d = DONE;
        res_d = res_n;
        cout_d = c32;
        v_d = c31 ^ c32;
      end
      DONE: if (own_q ? rsp_ready1 : rsp_ready0) begin
        state_d = IDLE;
        ptr_d = ~own_q;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q <= PRIO_INIT;
      own_q <= 1'b0;
      a_q <= '0;
      b_q <= '0;
      sub_q <= 1'b0;
      res_q <= '0;
      cout_q <= 1'b0;
      v_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      own_q <= own_d;
      a_q <= a_d;
      b_q <= b_d;
      sub_q <= sub_d;
      res_q <= res_d;
      cout_q <= cout_d;
      v_q <= v_d;
    end
  end
endmodule

// File: tb/tb_addsub_arbiter.sv
// tb_addsub_arbiter: directed and randomized checks of addsub_arbiter against an arithmetic reference model
module tb_addsub_arbiter;
  logic clk, rst, req0, req1, sub0, sub1, rsp_ready0, rsp_ready1;
  logic [31:0] a0, b0, a1, b1;
  logic gnt0, gnt1, rsp_valid0, rsp_valid1, res_cout, res_v, busy;
  logic [31:0] res;
  int checks = 0;
  int errors = 0;
  int ptr = 0;

  addsub_arbiter #(.PRIO_INIT(1'b0)) dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1), .sub0(sub0), .sub1(sub1),
    .gnt0(gnt0), .gnt1(gnt1), .rsp_valid0(rsp_valid0), .rsp_valid1(rsp_valid1),
    .rsp_ready0(rsp_ready0), .rsp_ready1(rsp_ready1),
    .res(res), .res_cout(res_cout), .res_v(res_v), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // {v, cout, res} from signed/unsigned arithmetic on the operands
  function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b, input bit s);
    longint sa, sb, sr;
    logic [32:0] u;
    logic [31:0] r;
    logic c, v;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    sr = s ? sa - sb : sa + sb;
    v = sr > 64'sd2147483647 || sr < -64'sd2147483648;
    u = {1'b0, a} + {1'b0, b};
    c = s ? (a >= b) : u[32];
    r = s ? a - b : a + b;
`ifdef ADDSUB_ARB_SAT_EN
    if (v) r = (sr > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
`endif
    return {v, c, r};
  endfunction

  function automatic logic [31:0] rnd();
    int k;
    k = $urandom_range(7);
    return k == 0 ? 32'h0 : k == 1 ? 32'hFFFF_FFFF : k == 2 ? 32'h7FFF_FFFF :
           k == 3 ? 32'h8000_0000 : k == 4 ? 32'h1 : $urandom;
  endfunction

  task automatic run(input bit r0, input bit r1,
                     input logic [31:0] x0, input logic [31:0] y0, input bit s0,
                     input logic [31:0] x1, input logic [31:0] y1, input bit s1,
                     input int hold);
    int w;
    logic [33:0] e;
    req0 = r0; req1 = r1;
    a0 = x0; b0 = y0; sub0 = s0; a1 = x1; b1 = y1; sub1 = s1;
    rsp_ready0 = 1'b0; rsp_ready1 = 1'b0;
    w = (r0 && r1) ? ptr : (r1 ? 1 : 0);
    e = w == 1 ? model(x1, y1, s1) : model(x0, y0, s0);
    #1;
    chk("gnt0_grant", gnt0, w == 0);
    chk("gnt1_grant", gnt1, w == 1);
    @(posedge clk); #1;
    if (w == 0) req0 = 1'b0; else req1 = 1'b0;
    a0 = $urandom; b0 = $urandom; a1 = $urandom; b1 = $urandom;
    sub0 = 1'($urandom); sub1 = 1'($urandom);
    rsp_ready0 = (w == 0) ? (hold == 0) : 1'b1;
    rsp_ready1 = (w == 1) ? (hold == 0) : 1'b1;
    #1;
    chk("exec_busy", busy, 1);
    chk("exec_gnt", gnt0 | gnt1, 0);
    chk("exec_valid", rsp_valid0 | rsp_valid1, 0);
    @(posedge clk); #1;
    chk("done_valid0", rsp_valid0, w == 0);
    chk("done_valid1", rsp_valid1, w == 1);
    chk("res", res, e[31:0]);
    chk("cout", res_cout, e[32]);
    chk("v", res_v, e[33]);
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      chk("hold_valid", w == 0 ? rsp_valid0 : rsp_valid1, 1);
      chk("hold_res", res, e[31:0]);
      chk("hold_gnt", gnt0 | gnt1, 0);
    end
    if (w == 0) rsp_ready0 = 1'b1; else rsp_ready1 = 1'b1;
    @(posedge clk); #1;
    rsp_ready0 = 1'b0; rsp_ready1 = 1'b0;
    #1;
    chk("after_valid", rsp_valid0 | rsp_valid1, 0);
    chk("after_busy", busy, 0);
    chk("after_loser_gnt", w == 0 ? gnt1 : gnt0, w == 0 ? req1 : req0);
    ptr = 1 - w;
  endtask

  initial begin
    rst = 1'b1; req0 = 1'b1; req1 = 1'b1;
    a0 = 0; b0 = 0; a1 = 0; b1 = 0; sub0 = 0; sub1 = 0;
    rsp_ready0 = 0; rsp_ready1 = 0;
    #12;
    chk("rst_gnt", {gnt0, gnt1}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_res", {res_cout, res_v, res}, 0);
    @(posedge clk); #1;
    rst = 1'b0; req0 = 1'b0; req1 = 1'b0;
    @(posedge clk); #1;
    run(1, 1, 32'd5, 32'd3, 1, 32'd1, 32'd1, 0, 0);
    run(0, 1, 32'd0, 32'd0, 0, 32'd1, 32'd1, 0, 1);
    run(1, 1, 32'd9, 32'd4, 0, 32'd7, 32'd2, 1, 0);
    run(1, 0, 32'h21, 32'h22, 0, 32'd0, 32'd0, 0, 0);
    run(0, 1, 32'd0, 32'd0, 0, 32'h7FFF_FFFF, 32'h1, 0, 0);
    run(1, 0, 32'h8000_0000, 32'h1, 1, 32'd0, 32'd0, 0, 2);
    run(1, 1, 32'hDEAD_BEEF, 32'h1234_5678, 1, 32'h1, 32'h2, 0, 5);
    run(0, 1, 32'd0, 32'd0, 0, 32'h1, 32'h2, 0, 0);
    run(1, 0, 32'd10, 32'd20, 1, 32'd0, 32'd0, 0, 0);
    req1 = 1'b1; a1 = 32'h55; b1 = 32'h66; sub1 = 1'b0;
    @(posedge clk); #1;
    req0 = 1'b1;
    rst = 1'b1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_gnt", {gnt0, gnt1}, 0);
    chk("arst_valid", {rsp_valid0, rsp_valid1}, 0);
    chk("arst_res", {res_cout, res_v, res}, 0);
    @(posedge clk); #1;
    chk("arst_hold_busy", busy, 0);
    rst = 1'b0; req0 = 1'b0; req1 = 1'b0;
    ptr = 0;
    #1;
    chk("post_rst_valid", {rsp_valid0, rsp_valid1}, 0);
    run(1, 1, 32'd100, 32'd1, 1, 32'd3, 32'd4, 0, 0);
    for (int i = 0; i < 150; i++) begin
      int r;
      if ($urandom_range(3) == 0) begin
        req0 = 1'b0; req1 = 1'b0;
        #1;
        chk("idle_busy", busy, 0);
        chk("idle_gnt", {gnt0, gnt1}, 0);
        @(posedge clk); #1;
      end
      r = $urandom_range(1, 3);
      run(r[0], r[1], rnd(), rnd(), 1'($urandom), rnd(), rnd(), 1'($urandom), $urandom_range(3));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/addsub_arbiter.md
ADDSUB_ARBITER -- requirements
Module: addsub_arbiter

Interface
REQ-001 Parameter PRIO_INIT, default 0: index of the requester holding priority after reset (0 or 1).
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 req0, req1  input  1 each  operation request from requester 0 / 1.
REQ-005 a0, b0, a1, b1  input  32 each  operands of requester 0 / 1.
REQ-006 sub0, sub1  input  1 each  1 = A-B, 0 = A+B.
REQ-007 gnt0, gnt1  output  1 each  operands of that requester are captured this cycle.
REQ-008 rsp_valid0, rsp_valid1  output  1 each  result for that requester is valid.
REQ-009 rsp_ready0, rsp_ready1  input  1 each  requester accepts the result.
REQ-010 res  output  32  registered result.
REQ-011 res_cout, res_v  output  1 each  registered carry-out and signed-overflow flag.
REQ-012 busy  output  1  high in any state other than IDLE.

Function
REQ-013 The FSM SHALL have three states: IDLE, EXEC and DONE.
REQ-014 In IDLE with at least one request, the block SHALL assert exactly one gnt combinationally, latch that requester's A, B, SUB and owner index on the clock edge, and go to EXEC.
REQ-015 Simultaneous req0 and req1 SHALL be resolved by the priority pointer; a single request SHALL be granted regardless of the pointer.
REQ-016 The priority pointer SHALL move to the other requester when a response completes.
REQ-017 In EXEC, the block SHALL compute A + (B XOR {32{SUB}}) + SUB through one 32-bit ripple add/sub, register res, res_cout and res_v = c31 XOR c32, and go to DONE.
REQ-018 In DONE, the block SHALL assert only the owner's rsp_valid and hold res and the flags stable.
REQ-019 The block SHALL leave DONE for IDLE on the edge where the owner's rsp_ready is high; rsp_ready may already be high when rsp_valid first rises.
REQ-020 Latency SHALL be fixed: gnt in cycle N, rsp_valid from cycle N+2, next grant no earlier than the cycle after completion.
REQ-021 gnt0 and gnt1 SHALL never be high together; gnt SHALL be low outside IDLE.
REQ-022 rsp_ready of the non-owner, and any rsp_ready outside DONE, SHALL be ignored.
REQ-023 Requests arriving outside IDLE SHALL wait; operands SHALL be sampled only in the grant cycle.
REQ-024 A request dropped before being granted SHALL leave no side effect.

Reset
REQ-025 While rst is high, the block SHALL set state to IDLE, pointer to PRIO_INIT, and res, res_cout, res_v, the latched operands and all gnt/rsp_valid/busy outputs to 0.
REQ-026 Reset in EXEC or DONE SHALL abandon the operation with no response delivered; the first grant after rst falls SHALL follow PRIO_INIT.

Configuration
REQ-027 Macro ADDSUB_ARB_SAT_EN defined: on res_v = 1, res SHALL saturate to 32'h7FFFFFFF when latched A[31] = 0, else to 32'h80000000; res_v and res_cout report the raw add.
REQ-028 Macro ADDSUB_ARB_SAT_EN undefined: res SHALL be the raw wrap-around sum.

Verification
REQ-029 PRIO_INIT=0; req0 only, A=32'h21, B=32'h22, SUB=0 -> gnt0 in cycle 0; rsp_valid0 in cycle 2; res=32'h43, cout=0, V=0.
REQ-030 Same cycle: req0 A=5 B=3 SUB=1 and req1 A=1 B=1 SUB=0 -> requester 0 first: res=2, cout=1, V=0. Then requester 1: res=2, cout=0. A further simultaneous request is granted to requester 0.
REQ-031 A=32'h7FFFFFFF + B=1 -> res=32'h80000000, V=1, cout=0; with ADDSUB_ARB_SAT_EN, res=32'h7FFFFFFF.
REQ-032 A=32'h80000000 - B=1 -> res=32'h7FFFFFFF, V=1, cout=1; with ADDSUB_ARB_SAT_EN, res=32'h80000000.
REQ-033 rsp_ready0 held low for 5 cycles while req1 is high -> rsp_valid0 and res stay constant, gnt1 stays low, and gnt1 rises the cycle after rsp_ready0 is accepted.
REQ-034 rst pulsed while in EXEC -> all outputs 0 immediately, no rsp_valid; a new request after reset is granted normally.
